// File: rtl/fp_div_nr_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_nr_seq
// Purpose  : Sequencer for a single-precision IEEE-754 divider. It accepts
//            an operand pair, resolves special operands in one cycle, and
//            otherwise runs a non-restoring mantissa recurrence that retires
//            BITS_PER_CYCLE quotient bits per cycle. It then normalises,
//            rounds to nearest-even and presents the result with flags.
// Ports    : clk, rst               clock / synchronous active-high reset
//            in_valid, in_ready     operand handshake (ready only in IDLE)
//            a, b                   dividend / divisor (IEEE-754 single)
//            out_valid, out_ready   result handshake (valid only in DONE)
//            result                 quotient (IEEE-754 single)
//            flags                  {invalid, div_by_zero, overflow,
//                                    underflow, inexact}
// Params   : BITS_PER_CYCLE         1 or 2 quotient bits per DIVIDE cycle
// Revision : 1.0  initial release
// ============================================================================
module fp_div_nr_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    localparam int          c_STEPS    = 26;
    localparam logic [4:0]  c_LAST_CNT = 5'(c_STEPS - BITS_PER_CYCLE);
    localparam logic [4:0]  c_CNT_INC  = 5'(BITS_PER_CYCLE);
    localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_DIVIDE  = 3'd2,
        S_NORM    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic [26:0] r_q,      r_d;       // signed partial remainder
    logic [23:0] d_q,      d_d;       // divisor significand 1.mb
    logic [25:0] q_q,      q_d;       // quotient, q[25] has weight 2^0
    logic [4:0]  cnt_q,    cnt_d;     // recurrence steps already retired
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q,  flags_d;

    // Denormals have exponent 0 and are therefore treated as zero.
    function automatic logic is_zero(input logic [7:0] e);
        return e == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [7:0] e, input logic [22:0] m);
        return (e == 8'hFF) && (m == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [7:0] e, input logic [22:0] m);
        return (e == 8'hFF) && (m != 23'd0);
    endfunction

    logic w_in_special;
    logic w_sign;
    logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;

    assign w_in_special = is_zero(a[30:23]) || (a[30:23] == 8'hFF) ||
                          is_zero(b[30:23]) || (b[30:23] == 8'hFF);
    assign w_sign   = a_q[31] ^ b_q[31];
    assign w_a_zero = is_zero(a_q[30:23]);
    assign w_a_inf  = is_inf(a_q[30:23], a_q[22:0]);
    assign w_a_nan  = is_nan(a_q[30:23], a_q[22:0]);
    assign w_b_zero = is_zero(b_q[30:23]);
    assign w_b_inf  = is_inf(b_q[30:23], b_q[22:0]);
    assign w_b_nan  = is_nan(b_q[30:23], b_q[22:0]);

    // Scratch values for the recurrence and the normalise/round step.
    logic [26:0]        w_r;
    logic [26:0]        w_r_sh;
    logic [25:0]        w_q;
    logic [26:0]        w_rem;
    logic [24:0]        w_qn;
    logic signed [9:0]  w_exp;
    logic [23:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        d_d      = d_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        w_r      = r_q;
        w_r_sh   = r_q;
        w_q      = q_q;
        w_rem    = r_q;
        w_qn     = q_q[24:0];
        w_exp    = 10'sd0;
        w_mant   = 24'd0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    r_d     = {3'b000, 1'b1, a[22:0]};
                    d_d     = {1'b1, b[22:0]};
                    q_d     = 26'd0;
                    cnt_d   = 5'd0;
                    state_d = w_in_special ? S_SPECIAL : S_DIVIDE;
                end
            end

            S_SPECIAL: begin
                state_d = S_DONE;
                if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                    result_d = c_QNAN;
                    flags_d  = 5'b10000;
                end else if (w_b_zero && !w_a_inf) begin
                    result_d = {w_sign, 8'hFF, 23'd0};
                    flags_d  = 5'b01000;
                end else if (w_a_inf) begin
                    result_d = {w_sign, 8'hFF, 23'd0};
                    flags_d  = 5'b00000;
                end else begin
                    result_d = {w_sign, 31'd0};
                    flags_d  = 5'b00000;
                end
            end

            S_DIVIDE: begin
                // The very first step compares R against D unshifted, so the
                // first quotient bit carries weight 2^0. Quotient bits are
                // shifted in MSB first and land at q[25] after all steps.
                for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                    w_r_sh = ((cnt_q == 5'd0) && (i == 0)) ? w_r : {w_r[25:0], 1'b0};
                    if (w_r[26]) begin
                        w_r = w_r_sh + {3'b000, d_q};
                    end else begin
                        w_r = w_r_sh - {3'b000, d_q};
                    end
                    w_q = {w_q[24:0], ~w_r[26]};
                end
                r_d   = w_r;
                q_d   = w_q;
                cnt_d = cnt_q + c_CNT_INC;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                state_d = S_DONE;
                // A negative final remainder is restored only to learn
                // whether any nonzero remainder is left for the sticky bit.
                w_rem    = r_q[26] ? (r_q + {3'b000, d_q}) : r_q;
                w_exp    = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                if (!q_q[25]) begin
                    w_qn  = {q_q[23:0], 1'b0};
                    w_exp = w_exp - 10'sd1;
                end
                w_guard  = w_qn[1];
                w_sticky = w_qn[0] | (|w_rem);
                w_inc    = w_guard & (w_sticky | w_qn[2]);
                w_mant   = {1'b0, w_qn[24:2]} + {23'd0, w_inc};
                // Carry out of the mantissa leaves the fraction at zero and
                // bumps the exponent by one.
                if (w_mant[23]) begin
                    w_exp = w_exp + 10'sd1;
                end
                if (w_exp >= 10'sd255) begin
                    result_d = {w_sign, 8'hFF, 23'd0};
                    flags_d  = 5'b00101;
                end else if (w_exp <= 10'sd0) begin
                    result_d = {w_sign, 31'd0};
                    flags_d  = 5'b00011;
                end else begin
                    result_d = {w_sign, w_exp[7:0], w_mant[22:0]};
                    flags_d  = {4'b0000, w_guard | w_sticky};
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            r_q      <= 27'd0;
            d_q      <= 24'd0;
            q_q      <= 26'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            d_q      <= d_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_nr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_nr_seq
// Purpose  : Scoreboard bench for fp_div_nr_seq. Two instances (1 and 2
//            quotient bits per cycle) see the same operands; expected
//            results come from an exact integer-division reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_div_nr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [31:0] result_v    [2];
    logic [4:0]  flags_v     [2];
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   hold     = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_nr_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_in), .b(b_in),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .result(result_v[0]), .flags(flags_v[0])
    );

    fp_div_nr_seq #(.BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_in), .b(b_in),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .result(result_v[1]), .flags(flags_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact quotient of the significands by integer division,
    // keeping one guard bit and folding the remainder into sticky.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [4:0] flg,
                                    output bit spc);
        logic [63:0] ma, mb, num, sig, rem;
        int  e;
        bit  s, za, zb, ia, ib, na, nb, guard, sticky;
        s   = a[31] ^ b[31];
        za  = (a[30:23] == 8'h00);
        zb  = (b[30:23] == 8'h00);
        ia  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        spc = 1'b1;
        flg = 5'b00000;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = 32'h7FC00000; flg = 5'b10000;
        end else if (zb && !ia) begin
            res = {s, 31'h7F800000}; flg = 5'b01000;
        end else if (ia) begin
            res = {s, 31'h7F800000};
        end else if (za || ib) begin
            res = {s, 31'h0};
        end else begin
            spc = 1'b0;
            ma  = {40'd0, 1'b1, a[22:0]};
            mb  = {40'd0, 1'b1, b[22:0]};
            e   = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (ma >= mb) begin
                num = ma << 24;
            end else begin
                num = ma << 25;
                e   = e - 1;
            end
            sig    = num / mb;
            rem    = num % mb;
            guard  = sig[0];
            sig    = sig >> 1;
            sticky = (rem != 0);
            if (guard && (sticky || sig[0])) sig = sig + 1;
            if (sig == 64'h100_0000) begin
                sig = 64'h80_0000;
                e   = e + 1;
            end
            if (e >= 255) begin
                res = {s, 31'h7F800000}; flg = 5'b00101;
            end else if (e <= 0) begin
                res = {s, 31'h0}; flg = 5'b00011;
            end else begin
                res = {s, 8'(e), sig[22:0]};
                flg = {4'b0000, guard | sticky};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        int sel;
        sel = $urandom_range(0, 9);
        x   = $urandom;
        case (sel)
            0: x[30:0] = 31'd0;
            1: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
            2: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
            3: x[30:23] = 8'h00;
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    // Presents one operand pair to both instances and records the
    // expectation for each at the moment that instance accepts it.
    task automatic issue_core(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [4:0] flg, input bit spc);
        bit   acc [2];
        exp_t e;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        a_in   = a;
        b_in   = b;
        for (int k = 0; k < 400 && !(acc[0] && acc[1]); k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                in_valid_v[u] = !acc[u];
                if (!acc[u] && in_ready_v[u]) begin
                    acc[u] = 1'b1;
                    e.res  = res;
                    e.flg  = flg;
                    e.acc  = cyc;
                    e.lat  = spc ? 2 : (26 / (u + 1)) + 2;
                    if (u == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                end
            end
        end
        if (!(acc[0] && acc[1])) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: got accepted=%0d%0d, expected 11", acc[0], acc[1]);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic [4:0]  flg;
        bit          spc;
        ref_div(a, b, res, flg, spc);
        issue_core(a, b, res, flg, spc);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", sb0.size(), sb1.size());
            sb0.delete();
            sb1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: drives out_ready, tracks first-valid cycle for latency,
    // checks that the presented result is held, and scores each handshake.
    initial begin
        bit          seen [2];
        logic [31:0] fres [2];
        logic [4:0]  fflg [2];
        int          fcyc [2];
        exp_t        e;
        bit          got;
        for (int u = 0; u < 2; u++) begin
            seen[u]        = 1'b0;
            fres[u]        = 32'd0;
            fflg[u]        = 5'd0;
            fcyc[u]        = 0;
            out_ready_v[u] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    seen[u]        = 1'b0;
                    out_ready_v[u] = 1'b0;
                end else begin
                    out_ready_v[u] = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
                    if (out_valid_v[u]) begin
                        if (!seen[u]) begin
                            seen[u] = 1'b1;
                            fres[u] = result_v[u];
                            fflg[u] = flags_v[u];
                            fcyc[u] = cyc;
                        end else begin
                            chk($sformatf("dut%0d held_result", u), result_v[u], fres[u]);
                            chk($sformatf("dut%0d held_flags", u), 32'(flags_v[u]), 32'(fflg[u]));
                        end
                        if (out_ready_v[u]) begin
                            got = 1'b0;
                            if (u == 0 && sb0.size() > 0) begin
                                e = sb0.pop_front(); got = 1'b1;
                            end else if (u == 1 && sb1.size() > 0) begin
                                e = sb1.pop_front(); got = 1'b1;
                            end
                            if (!got) begin
                                n_checks++;
                                n_err++;
                                $display("FAIL dut%0d unexpected_output: got result %h, expected no output", u, result_v[u]);
                            end else begin
                                chk($sformatf("dut%0d result", u), result_v[u], e.res);
                                chk($sformatf("dut%0d flags", u), 32'(flags_v[u]), 32'(e.flg));
                                chk($sformatf("dut%0d latency", u), 32'(fcyc[u] - e.acc), 32'(e.lat));
                            end
                            seen[u] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("dut%0d reset out_valid", u), 32'(out_valid_v[u]), 32'd0);
            chk($sformatf("dut%0d reset in_ready", u), 32'(in_ready_v[u]), 32'd1);
            chk($sformatf("dut%0d reset result", u), result_v[u], 32'd0);
            chk($sformatf("dut%0d reset flags", u), 32'(flags_v[u]), 32'd0);
        end
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        issue_core(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0);
        issue_core(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0);
        issue_core(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1);
        issue_core(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1);
        issue_core(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 1'b0);
        issue_core(32'h00800000, 32'h4B000000, 32'h00000000, 5'b00011, 1'b0);
        issue_core(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 1'b1);
        issue_core(32'h7F800000, 32'hBF800000, 32'hFF800000, 5'b00000, 1'b1);
        issue_core(32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1'b1);
        issue_core(32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1'b1);
        issue_core(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1'b1);
        issue_core(32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1'b1);
        issue_core(32'h80000000, 32'h40A00000, 32'h80000000, 5'b00000, 1'b1);
        drain(3000);

        // Consumer stalls in DONE: output held, input side stays closed.
        hold = 1'b1;
        issue_core(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0);
        k = 0;
        while (!(out_valid_v[0] && out_valid_v[1]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!(out_valid_v[0] && out_valid_v[1])) begin
            n_checks++;
            n_err++;
            $display("FAIL hold_wait: got out_valid=%0d%0d, expected 11", out_valid_v[0], out_valid_v[1]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_in          = 32'h40C00000;
            b_in          = 32'h40000000;
            in_valid_v[0] = 1'b1;
            in_valid_v[1] = 1'b1;
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("dut%0d hold in_ready", u), 32'(in_ready_v[u]), 32'd0);
                chk($sformatf("dut%0d hold out_valid", u), 32'(out_valid_v[u]), 32'd1);
            end
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        hold          = 1'b0;
        drain(500);
        repeat (40) @(negedge clk);

        // Reset in the middle of DIVIDE abandons the operation.
        @(negedge clk);
        a_in          = 32'h40C00000;
        b_in          = 32'h40000000;
        in_valid_v[0] = 1'b1;
        in_valid_v[1] = 1'b1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("dut%0d pre_reset in_ready", u), 32'(in_ready_v[u]), 32'd1);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("dut%0d midop_reset out_valid", u), 32'(out_valid_v[u]), 32'd0);
            chk($sformatf("dut%0d midop_reset in_ready", u), 32'(in_ready_v[u]), 32'd1);
            chk($sformatf("dut%0d midop_reset result", u), result_v[u], 32'd0);
        end
        rst = 1'b0;
        issue_core(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0);
        drain(500);

        // Randomised operands against the reference model.
        for (int n = 0; n < 60; n++) begin
            issue(rand_op(), rand_op());
        end
        drain(3000);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
